mpu_seq_ctrl: RTL and testbench
===============================

Name: mpu_seq_ctrl

Overview:
- Command-driven sequencer for the int8 matrix unit.
- Per command, fetches activation rows byte-by-byte over the DRAM byte bus and presents each completed row to the systolic array.
- Tracks in-flight rows through the array's fixed latency and emits one accumulator write strobe (index plus accumulate/overwrite mode) as each row's result column emerges.
- Sits between the host command interface, DRAM, the sa instance and the 16-entry accumulator file.

Parameters:
DIM, 8, array edge; bytes per activation row
ADDR_W, 16, DRAM byte address width
ACC_DEPTH, 16, accumulator entries; power of two
SA_LAT, 16, cycles from sa_row_valid to that row's result being valid at the array output

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_src  in  ADDR_W  DRAM byte address of row 0
cmd_rows  in  5  row count, 0..ACC_DEPTH
cmd_acc_base  in  log2(ACC_DEPTH)  accumulator index for row 0
cmd_accum  in  1  1=add into accumulator, 0=overwrite
mem_rd_en  out  1  one-cycle byte read request
mem_addr  out  ADDR_W  read address
mem_rd_valid  in  1  read data valid (latency >=1, one outstanding read)
mem_rd_data  in  8  read byte
sa_row_valid  out  1  sa_row is valid this cycle
sa_row  out  DIM*8  activation row; byte k at bits [8k+7:8k]
acc_wr_en  out  1  result row retires this cycle
acc_wr_idx  out  log2(ACC_DEPTH)  target accumulator
acc_wr_accum  out  1  latched cmd_accum
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, mem_rd_en=0, mem_addr=0, sa_row_valid=0, sa_row=0, acc_wr_en=0, acc_wr_idx=0, acc_wr_accum=0. Retire pipeline cleared. State=IDLE.
- The FSM states and transitions are:
  - IDLE: cmd_ready=1. On acceptance, latch all command fields and clear the row and byte counters. If cmd_rows=0, go to DONE with no reads; otherwise go to FETCH.
  - FETCH: assert mem_rd_en with mem_addr = src + row*DIM + k for byte k, then wait for mem_rd_valid. On valid, write byte k into the row buffer. The next request for byte k+1 is issued in the same cycle as the valid, so a latency-1 memory sustains 1 byte/cycle. When the valid for byte DIM-1 is captured, go to ISSUE.
  - ISSUE: exactly one cycle with sa_row_valid=1 and sa_row=row buffer. Push a token {idx=(acc_base+row) mod ACC_DEPTH} into the retire pipeline. row++. Go to FETCH if row<cmd_rows, else DRAIN.
  - DRAIN: wait until the retire pipeline is empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- mem_rd_data is ignored unless mem_rd_valid=1. mem_rd_valid while no read is outstanding is ignored.
- Retire pipeline:
  - SA_LAT-deep shift register, advancing every cycle independent of FSM state.
  - A token emerging drives acc_wr_en=1, acc_wr_idx=token idx, acc_wr_accum=latched mode, for one cycle.
  - Rows retire in issue order, exactly SA_LAT cycles after their issue cycle.
- Arithmetic and wrap:
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Accumulator index wraps modulo ACC_DEPTH.
  - cmd_rows > ACC_DEPTH is clamped to ACC_DEPTH.
- Command handling: cmd_ready=0 outside IDLE, so no command queuing. A command offered in the DONE cycle is accepted in the following IDLE cycle.
- Reset mid-operation: immediate return to IDLE. Tokens in flight are discarded, so no acc_wr_en follows. No done pulse. An outstanding DRAM read response arriving after reset is ignored.
- done is asserted exactly one cycle after the final acc_wr_en.

Optional Feature:
MPU_SEQ_PERF_EN:
- Defined: adds outputs perf_busy (32) and perf_stall (32).
  - perf_busy increments every cycle busy=1.
  - perf_stall increments every FETCH cycle in which a read is outstanding and mem_rd_valid=0.
  - Both saturate at 2^32-1 and are cleared by rst only, not per command.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Latency-1 memory, src=0x0100, rows=2, base=3, accum=0, accept at cycle 0:
  - 16 reads at 0x0100..0x010F.
  - sa_row_valid at cycles 10 and 20.
  - acc_wr_en at cycles 26 (idx 3) and 36 (idx 4), acc_wr_accum=0.
  - done at cycle 37.
- Memory returning byte k = k+1 with latency 4: sa_row = 0x0807060504030201. 4-cycle gap between consecutive mem_rd_en.
- rows=3, base=15, accum=1: writes to idx 15, 0, 1 with acc_wr_accum=1.
- src=0xFFFC, rows=1: reads at FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- rows=0: done one cycle after acceptance. No mem_rd_en, no sa_row_valid, no acc_wr_en.
- rst asserted 3 cycles after the first sa_row_valid of a 2-row command:
  - Outputs return to reset values; no acc_wr_en, no done.
  - A new command is accepted in the first cycle after rst deasserts.

Source files
------------

// File: rtl/mpu_seq_ctrl.sv
// Command sequencer for the int8 matrix unit: byte-wise row fetch, array issue, result retire.
// Optional MPU_SEQ_PERF_EN adds saturating busy/stall counters.
module mpu_seq_ctrl #(
  parameter int DIM       = 8,
  parameter int ADDR_W    = 16,
  parameter int ACC_DEPTH = 16,
  parameter int SA_LAT    = 16,
  localparam int IW = $clog2(ACC_DEPTH),
  localparam int RW = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [RW-1:0]     cmd_rows,
  input  logic [IW-1:0]     cmd_acc_base,
  input  logic              cmd_accum,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [7:0]        mem_rd_data,
  output logic              sa_row_valid,
  output logic [DIM*8-1:0]  sa_row,
  output logic              acc_wr_en,
  output logic [IW-1:0]     acc_wr_idx,
  output logic              acc_wr_accum,
  output logic              busy,
  output logic              done
`ifdef MPU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall
`endif
);

  localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [SA_LAT-1:0] LMASK = ~(SA_LAT'(1) << (SA_LAT - 1));

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [RW-1:0]     r_rows;
  logic [RW-1:0]     r_row;
  logic [IW-1:0]     r_base;
  logic              r_accum;
  logic [KW-1:0]     r_k;
  logic              r_out;
  logic [DIM*8-1:0]  r_buf;
  logic              r_sav;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic [SA_LAT-1:0] r_pv;
  logic [IW-1:0]     r_pidx [SA_LAT];

  logic              w_fetch;
  logic              w_cap;
  logic              w_last;
  logic              w_rd_en;
  logic [KW-1:0]     w_kreq;
  logic [RW-1:0]     w_rows_cl;
  logic [RW-1:0]     w_row_nx;

  assign w_fetch   = (r_state == S_FETCH);
  assign w_cap     = w_fetch && r_out && mem_rd_valid;
  assign w_last    = w_cap && (r_k == KW'(DIM - 1));
  // Next byte is requested in the same cycle its predecessor lands.
  assign w_rd_en   = w_fetch && (!r_out || (w_cap && !w_last));
  assign w_kreq    = r_out ? r_k + KW'(1) : r_k;
  assign w_rows_cl = (cmd_rows > RW'(ACC_DEPTH)) ? RW'(ACC_DEPTH) : cmd_rows;
  assign w_row_nx  = r_row + RW'(1);

  assign cmd_ready    = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign mem_rd_en    = w_rd_en;
  assign mem_addr     = w_rd_en ? r_src + ADDR_W'(w_kreq) : '0;
  assign sa_row_valid = r_sav;
  assign sa_row       = r_buf;
  assign acc_wr_en    = r_pv[SA_LAT-1];
  assign acc_wr_idx   = r_pidx[SA_LAT-1];
  assign acc_wr_accum = r_accum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_rows  <= '0;
      r_row   <= '0;
      r_base  <= '0;
      r_accum <= 1'b0;
      r_k     <= '0;
      r_out   <= 1'b0;
      r_buf   <= '0;
      r_sav   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_rd_en)
        r_out <= 1'b1;
      else if (w_cap)
        r_out <= 1'b0;
      if (w_cap)
        r_buf[8*r_k +: 8] <= mem_rd_data;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_src   <= cmd_src;
            r_rows  <= w_rows_cl;
            r_base  <= cmd_acc_base;
            r_accum <= cmd_accum;
            r_row   <= '0;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_rows_cl == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_cap)
            r_k <= r_k + KW'(1);
          if (w_last) begin
            r_k     <= '0;
            r_sav   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_sav   <= 1'b0;
          r_row   <= w_row_nx;
          r_src   <= r_src + ADDR_W'(DIM);
          r_state <= (w_row_nx < r_rows) ? S_FETCH : S_DRAIN;
        end
        S_DRAIN: begin
          // Leave when only the emerging token (if any) remains.
          if ((r_pv & LMASK) == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < SA_LAT; i++)
        r_pidx[i] <= '0;
    end else begin
      for (int i = SA_LAT - 1; i > 0; i--) begin
        r_pv[i]   <= r_pv[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
      r_pv[0]   <= (r_state == S_ISSUE);
      r_pidx[0] <= r_base + r_row[IW-1:0];
    end
  end

`ifdef MPU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (r_busy && perf_busy != '1)
        perf_busy <= perf_busy + 32'd1;
      if (w_fetch && r_out && !mem_rd_valid && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mpu_seq_ctrl.sv
// Scoreboard bench for mpu_seq_ctrl: expected reads, rows, writes and done
// are queued at command time and consumed by a negedge monitor.
module tb_mpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src;
  logic [4:0]  cmd_rows;
  logic [3:0]  cmd_acc_base;
  logic        cmd_accum;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        sa_row_valid;
  logic [63:0] sa_row;
  logic        acc_wr_en;
  logic [3:0]  acc_wr_idx;
  logic        acc_wr_accum;
  logic        busy;
  logic        done;

  mpu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_rows(cmd_rows),
    .cmd_acc_base(cmd_acc_base), .cmd_accum(cmd_accum),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .sa_row_valid(sa_row_valid), .sa_row(sa_row),
    .acc_wr_en(acc_wr_en), .acc_wr_idx(acc_wr_idx),
    .acc_wr_accum(acc_wr_accum),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [63:0] row; } sa_e;
  typedef struct { int cyc; logic [3:0] idx; logic acc; } wr_e;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   ign   = 0;
  int   lat   = 1;
  int   q_addr [$];
  sa_e  q_sa   [$];
  wr_e  q_wr   [$];
  int   q_done [$];
  int   rd_cyc [$];

  always @(posedge clk) cyc++;

  // Memory: byte at address a reads as a[7:0]+1, after lat cycles.
  logic        req_s = 1'b0;
  logic [15:0] addr_s;
  logic [15:0] pa;
  int          cnt = 0;

  always @(negedge clk) begin
    req_s  = mem_rd_en;
    addr_s = mem_addr;
  end

  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= pa[7:0] + 8'd1;
      end
    end
    if (req_s) begin
      if (lat == 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= addr_s[7:0] + 8'd1;
      end else begin
        cnt = lat - 1;
        pa  = addr_s;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !ign) begin
      if (mem_rd_en) begin
        int ea;
        rd_cyc.push_back(cyc);
        total++;
        if (q_addr.size() == 0) begin
          bad++;
          $display("FAIL rd_unexp cyc=%0d addr=%h", cyc, mem_addr);
        end else begin
          ea = q_addr.pop_front();
          if (mem_addr !== ea[15:0]) begin
            bad++;
            $display("FAIL rd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, ea[15:0]);
          end
        end
      end
      if (sa_row_valid) begin
        sa_e e;
        total++;
        if (q_sa.size() == 0) begin
          bad++;
          $display("FAIL sa_unexp cyc=%0d", cyc);
        end else begin
          e = q_sa.pop_front();
          if (sa_row !== e.row || cyc != e.cyc) begin
            bad++;
            $display("FAIL sa_row cyc=%0d row=%h exp_cyc=%0d exp_row=%h", cyc, sa_row, e.cyc, e.row);
          end
        end
      end
      if (acc_wr_en) begin
        wr_e w;
        total++;
        if (q_wr.size() == 0) begin
          bad++;
          $display("FAIL wr_unexp cyc=%0d idx=%0d", cyc, acc_wr_idx);
        end else begin
          w = q_wr.pop_front();
          if (acc_wr_idx !== w.idx || acc_wr_accum !== w.acc || cyc != w.cyc) begin
            bad++;
            $display("FAIL acc_wr cyc=%0d idx=%0d acc=%b exp_cyc=%0d exp_idx=%0d exp_acc=%b",
                     cyc, acc_wr_idx, acc_wr_accum, w.cyc, w.idx, w.acc);
          end
        end
      end
      if (done) begin
        int ed;
        total++;
        if (q_done.size() == 0) begin
          bad++;
          $display("FAIL done_unexp cyc=%0d", cyc);
        end else begin
          ed = q_done.pop_front();
          if (cyc != ed) begin
            bad++;
            $display("FAIL done_cyc got=%0d exp=%0d", cyc, ed);
          end
        end
      end
    end
  end

  // Called at a negedge while the DUT is idle.
  task automatic run_cmd(input logic [15:0] src, input int rows,
                         input int base, input bit acc, input int l);
    int r_eff;
    int t0;
    int per;
    lat   = l;
    r_eff = (rows > 16) ? 16 : rows;
    per   = 8 * l + 2;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready got=%b exp=1", cmd_ready);
    end
    cmd_valid    = 1'b1;
    cmd_src      = src;
    cmd_rows     = 5'(rows);
    cmd_acc_base = 4'(base);
    cmd_accum    = acc;
    t0 = cyc;
    for (int r = 0; r < r_eff; r++) begin
      sa_e e;
      wr_e w;
      e.row = '0;
      for (int k = 0; k < 8; k++) begin
        logic [15:0] a;
        a = src + 16'(r * 8 + k);
        q_addr.push_back(int'(a));
        e.row[8*k +: 8] = a[7:0] + 8'd1;
      end
      e.cyc = t0 + (r + 1) * per;
      q_sa.push_back(e);
      w.cyc = e.cyc + 16;
      w.idx = 4'((base + r) % 16);
      w.acc = acc;
      q_wr.push_back(w);
    end
    q_done.push_back(r_eff == 0 ? t0 + 1 : t0 + r_eff * per + 17);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3000 && q_done.size() != 0; i++)
      @(posedge clk);
    total++;
    if (q_done.size() != 0) begin
      bad++;
      $display("FAIL done_timeout got=none exp=%0d", q_done[0]);
    end
    total++;
    if (q_addr.size() + q_sa.size() + q_wr.size() != 0) begin
      bad++;
      $display("FAIL leftover rd=%0d sa=%0d wr=%0d exp=0",
               q_addr.size(), q_sa.size(), q_wr.size());
    end
    q_addr.delete();
    q_sa.delete();
    q_wr.delete();
    q_done.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_ctl rdy=%b busy=%b done=%b exp=1,0,0", cmd_ready, busy, done);
    end
    total++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 16'h0) begin
      bad++;
      $display("FAIL rst_mem en=%b addr=%h exp=0,0000", mem_rd_en, mem_addr);
    end
    total++;
    if (sa_row_valid !== 1'b0 || sa_row !== 64'h0) begin
      bad++;
      $display("FAIL rst_sa v=%b row=%h exp=0,0", sa_row_valid, sa_row);
    end
    total++;
    if (acc_wr_en !== 1'b0 || acc_wr_idx !== 4'h0 || acc_wr_accum !== 1'b0) begin
      bad++;
      $display("FAIL rst_acc en=%b idx=%0d acc=%b exp=0,0,0", acc_wr_en, acc_wr_idx, acc_wr_accum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_cmd(16'h0100, 2, 3, 1'b0, 1);
  endtask

  task automatic test_latency4();
    @(negedge clk);
    rd_cyc.delete();
    run_cmd(16'h0200, 1, 0, 1'b0, 4);
    total++;
    if (rd_cyc.size() != 8) begin
      bad++;
      $display("FAIL lat4_nreq got=%0d exp=8", rd_cyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        total++;
        if (rd_cyc[i] - rd_cyc[i-1] != 4) begin
          bad++;
          $display("FAIL lat4_gap i=%0d got=%0d exp=4", i, rd_cyc[i] - rd_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_idx_wrap();
    @(negedge clk);
    run_cmd(16'h0400, 3, 15, 1'b1, 1);
  endtask

  task automatic test_addr_wrap();
    @(negedge clk);
    run_cmd(16'hFFFC, 1, 7, 1'b0, 2);
  endtask

  task automatic test_zero_rows();
    @(negedge clk);
    run_cmd(16'h0500, 0, 2, 1'b1, 1);
  endtask

  task automatic test_clamp();
    @(negedge clk);
    run_cmd(16'h1000, 17, 5, 1'b1, 1);
  endtask

  task automatic test_reset_mid();
    int i;
    @(negedge clk);
    ign          = 1'b1;
    lat          = 1;
    cmd_valid    = 1'b1;
    cmd_src      = 16'h0300;
    cmd_rows     = 5'd2;
    cmd_acc_base = 4'd9;
    cmd_accum    = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (i = 0; i < 100 && !sa_row_valid; i++)
      @(negedge clk);
    total++;
    if (!sa_row_valid) begin
      bad++;
      $display("FAIL mid_sa_timeout got=0 exp=1");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ign = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 ||
        sa_row_valid !== 1'b0 || acc_wr_en !== 1'b0 || sa_row !== 64'h0) begin
      bad++;
      $display("FAIL mid_rst busy=%b done=%b rd=%b sav=%b wr=%b row=%h exp=0s",
               busy, done, mem_rd_en, sa_row_valid, acc_wr_en, sa_row);
    end
    run_cmd(16'h0600, 1, 1, 1'b0, 1);
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_src      = '0;
    cmd_rows     = '0;
    cmd_acc_base = '0;
    cmd_accum    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'h00;
    test_reset();
    test_basic();
    test_latency4();
    test_idx_wrap();
    test_addr_wrap();
    test_zero_rows();
    test_clamp();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
